// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a byte FIFO that a
// programmable-rate serializer drains onto the tx line, LSB first.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write_enable,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_BAUD   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e           state_q,    state_d;
  logic             tx_q,       tx_d;
  logic [7:0]       shift_q,    shift_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic [15:0]      cyc_cnt_q,  cyc_cnt_d;
  logic [15:0]      baud_q,     baud_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [7:0]       fifo_mem [FIFO_DEPTH];

  reg_e       reg_sel;
  logic       bus_wr;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       bit_done;
  logic [7:0] head_byte;
  logic [7:0] count_byte;
  logic       unused_bits;

  assign reg_sel     = reg_e'(address[3:2]);
  assign bus_wr      = sel & write_enable;
  assign push_req    = bus_wr & (reg_sel == REG_TXDATA);
  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign push_ok     = push_req & ~fifo_full;
  assign head_byte   = fifo_mem[rd_ptr_q];
  assign bit_done    = (cyc_cnt_q == '0);
  assign count_byte  = 8'(count_q);
  assign unused_bits = ^{address[ADDR_WIDTH-1:4], address[1:0], write_data[31:16]};

  // Register-file updates. A push into a full FIFO sets overflow even if the
  // serializer pops in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    baud_d     = baud_q;
    overflow_d = overflow_q;
    if (bus_wr && reg_sel == REG_BAUD) begin
      baud_d = (write_data[15:0] == '0) ? 16'd1 : write_data[15:0];
    end
    if (bus_wr && reg_sel == REG_STATUS && write_data[3]) begin
      overflow_d = 1'b0;
    end
    if (push_req && fifo_full) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Serializer. The cycle counter reloads from the live BAUD_DIV at every bit
  // boundary, so a divider change lands on the next bit.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    pop       = 1'b0;

    if (state_q != S_IDLE) begin
      cyc_cnt_d = bit_done ? (baud_q - 16'd1) : (cyc_cnt_q - 16'd1);
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = head_byte;
          cyc_cnt_d = baud_q - 16'd1;
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head_byte;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      baud_q     <= DEFAULT_DIV;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      baud_q     <= baud_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= write_data[7:0];
    end
  end

  always_comb begin
    read_data = '0;
    if (sel) begin
      case (reg_sel)
        REG_STATUS: read_data = {16'h0000, count_byte, 4'h0, overflow_q,
                                 (state_q != S_IDLE), fifo_empty, fifo_full};
        REG_BAUD:   read_data = {16'h0000, baud_q};
        default:    read_data = '0;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx: a frame-level model (byte queue plus
// current 10-bit frame) is compared with tx, busy and read_data every cycle.
module tb_mmio_uart_tx;

  localparam int          DEPTH = 8;
  localparam logic [15:0] DDIV  = 16'd868;
  localparam int          AW    = 10;

  logic          clk;
  logic          reset;
  logic          sel;
  logic [AW-1:0] address;
  logic          write_enable;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          tx;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  mmio_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(DDIV),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .address     (address),
    .write_enable(write_enable),
    .write_data  (write_data),
    .read_data   (read_data),
    .tx          (tx),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is the 10-bit pattern {stop, data, start}
  // played bit by bit, each bit lasting the divider in force when it began.
  logic [7:0] m_q[$];
  bit         m_valid  = 1'b0;
  bit         m_active;
  bit         m_ovf;
  int         m_baud;
  int         m_bit;
  int         m_left;
  logic [9:0] m_frame;
  logic       m_tx;
  bit         pre_full;
  int         pre_baud;
  bit         m_wr;
  logic [1:0] m_off;

  task automatic start_frame(input int b);
    logic [7:0] d;
    d        = m_q.pop_front();
    m_frame  = {1'b1, d, 1'b0};
    m_bit    = 0;
    m_left   = b;
    m_active = 1'b1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
      m_baud   = int'(DDIV);
      m_bit    = 0;
      m_left   = 0;
      m_tx     = 1'b1;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      pre_full = (m_q.size() == DEPTH);
      pre_baud = m_baud;
      m_wr     = sel && write_enable;
      m_off    = address[3:2];
      if (!m_active) begin
        if (m_q.size() > 0) start_frame(pre_baud);
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_bit == 9) begin
            if (m_q.size() > 0) start_frame(pre_baud);
            else m_active = 1'b0;
          end else begin
            m_bit++;
            m_left = pre_baud;
          end
        end
      end
      if (m_wr && m_off == 2'd0) begin
        if (pre_full) m_ovf = 1'b1;
        else m_q.push_back(write_data[7:0]);
      end
      if (m_wr && m_off == 2'd1 && write_data[3]) m_ovf = 1'b0;
      if (m_wr && m_off == 2'd2) m_baud = (write_data[15:0] == 16'd0) ? 1 : int'(write_data[15:0]);
      m_tx = m_active ? m_frame[m_bit] : 1'b1;
    end
  end

  function automatic logic [31:0] exp_read();
    logic [31:0] r;
    r = 32'd0;
    if (sel) begin
      if (address[3:2] == 2'd1) begin
        r[0]    = (m_q.size() == DEPTH);
        r[1]    = (m_q.size() == 0);
        r[2]    = m_active;
        r[3]    = m_ovf;
        r[15:8] = 8'(m_q.size());
      end else if (address[3:2] == 2'd2) begin
        r[15:0] = 16'(m_baud);
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (m_valid && !reset) begin
      check("tx", {31'd0, tx}, {31'd0, m_tx});
      check("busy", {31'd0, busy}, {31'd0, (m_active || m_q.size() > 0)});
      check("read_data", read_data, exp_read());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    sel          = 1'b0;
    write_enable = 1'($urandom);
    address      = AW'($urandom);
    write_data   = $urandom;
  endtask

  task automatic bus_op(input logic s, input logic we, input logic [1:0] off, input logic [31:0] data);
    sel          = s;
    write_enable = we;
    address      = AW'($urandom);
    address[3:2] = off;
    write_data   = data;
    step();
    set_idle();
  endtask

  task automatic rd_lit(input logic [1:0] off, input logic [31:0] exp, input string name);
    sel          = 1'b1;
    write_enable = 1'b0;
    address      = AW'($urandom);
    address[3:2] = off;
    write_data   = $urandom;
    #1;
    check(name, read_data, exp);
    step();
    set_idle();
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && busy !== 1'b0; i++) step();
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [19:0] b2b_exp;
  int          r;

  initial begin
    reset = 1'b1;
    set_idle();
    repeat (3) step();
    reset = 1'b0;

    // Reset state.
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rd_lit(2'd1, 32'h0000_0002, "rst_status");
    rd_lit(2'd2, 32'h0000_0364, "rst_baud");

    // 0x55 at divider 4: 40-cycle frame, alternating bits every 4 cycles.
    bus_op(1'b1, 1'b1, 2'd2, 32'd4);
    bus_op(1'b1, 1'b1, 2'd0, 32'h0000_0055);
    check("f55_busy_n", {31'd0, busy}, 32'd1);
    check("f55_tx_n", {31'd0, tx}, 32'd1);
    for (int i = 1; i <= 40; i++) begin
      step();
      check("f55_tx", {31'd0, tx}, 32'(((i - 1) / 4) % 2));
    end
    step();
    check("f55_end_busy", {31'd0, busy}, 32'd0);
    check("f55_end_tx", {31'd0, tx}, 32'd1);

    // Back-to-back frames at divider 1: A3 then 0F with no idle gap.
    bus_op(1'b1, 1'b1, 2'd2, 32'd1);
    b2b_exp = 20'b0110_0010_1101_1110_0001;
    bus_op(1'b1, 1'b1, 2'd0, 32'h0000_00A3);
    bus_op(1'b1, 1'b1, 2'd0, 32'h0000_000F);
    check("b2b_tx", {31'd0, tx}, {31'd0, b2b_exp[19]});
    for (int i = 1; i < 20; i++) begin
      step();
      check("b2b_tx", {31'd0, tx}, {31'd0, b2b_exp[19-i]});
    end
    step();
    check("b2b_end_busy", {31'd0, busy}, 32'd0);

    // Overflow: 10 pushes at divider 8, the tenth is dropped.
    bus_op(1'b1, 1'b1, 2'd2, 32'd8);
    for (int i = 0; i < 10; i++) bus_op(1'b1, 1'b1, 2'd0, $urandom);
    rd_lit(2'd1, 32'h0000_080D, "ovf_status");
    bus_op(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF);
    rd_lit(2'd1, 32'h0000_0805, "ovf_cleared");
    wait_idle(1000);

    // Divider 0 stores 1; sel low and reserved offset have no effect.
    bus_op(1'b1, 1'b1, 2'd2, 32'hABCD_0000);
    rd_lit(2'd2, 32'h0000_0001, "baud_zero");
    bus_op(1'b0, 1'b1, 2'd2, 32'd5);
    bus_op(1'b0, 1'b1, 2'd0, 32'h0000_0077);
    rd_lit(2'd2, 32'h0000_0001, "sel_low_baud");
    rd_lit(2'd1, 32'h0000_0002, "sel_low_status");
    bus_op(1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF);
    rd_lit(2'd3, 32'h0000_0000, "rsvd_read");
    sel          = 1'b0;
    address      = AW'($urandom);
    address[3:2] = 2'd1;
    #1;
    check("unsel_read", read_data, 32'd0);
    step();
    set_idle();

    // Reset in the middle of a data bit.
    bus_op(1'b1, 1'b1, 2'd2, 32'd4);
    bus_op(1'b1, 1'b1, 2'd0, 32'h0000_00C6);
    repeat (10) step();
    pulse_reset();
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rd_lit(2'd1, 32'h0000_0002, "midrst_status");
    rd_lit(2'd2, 32'h0000_0364, "midrst_baud");
    bus_op(1'b1, 1'b1, 2'd2, 32'd2);
    bus_op(1'b1, 1'b1, 2'd0, 32'h0000_003C);
    wait_idle(100);

    // Randomized traffic checked cycle by cycle against the model.
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      bus_op(1'b1, 1'b1, 2'd0, $urandom);
      else if (r < 36) bus_op(1'b1, 1'b1, 2'd1, $urandom);
      else if (r < 40) bus_op(1'b1, 1'b1, 2'd2, {16'($urandom), 16'($urandom_range(0, 3))});
      else if (r < 44) bus_op(1'b1, 1'b1, 2'd3, $urandom);
      else if (r < 64) bus_op(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom);
      else if (r < 65) begin
        pulse_reset();
        bus_op(1'b1, 1'b1, 2'd2, 32'd2);
      end else bus_op(1'b0, 1'($urandom), 2'($urandom_range(0, 3)), $urandom);
    end
    wait_idle(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
